alarm_ring_ctrl: RTL and testbench
==================================

ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 SHALL have port: clk_1hz  in  1  1 Hz system clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have port: cur_h  in  6  current hour, 0..23.
REQ-004 SHALL have port: cur_m  in  6  current minute, 0..59.
REQ-005 SHALL have port: cur_s  in  6  current second, 0..59.
REQ-006 SHALL have port: alm_h  in  6  alarm hour from the alarm-set stage, 0..23.
REQ-007 SHALL have port: alm_m  in  6  alarm minute from the alarm-set stage, 0..59.
REQ-008 SHALL have port: alm_en  in  1  alarm armed (alarm-set stage LED flag).
REQ-009 SHALL have port: stop  in  1  level, sampled each clock; dismisses the alarm.
REQ-010 SHALL have port: snooze  in  1  level, sampled each clock; requests snooze.
REQ-011 SHALL have port: buzz  out  1  registered buzzer drive.
REQ-012 SHALL have port: ringing  out  1  registered; 1 while in RING.
REQ-013 SHALL have port: snoozing  out  1  registered; 1 while in SNOOZE.
REQ-014 SHALL have port: snz_left  out  2  registered; snoozes remaining, 0..3.

Function
REQ-015 SHALL implement FSM states IDLE, RING, SNOOZE.
REQ-016 IDLE->RING when alm_en=1 and cur_h==alm_h and cur_m==alm_m and cur_s==0; ring_cnt cleared to 0.
REQ-017 Match is checked only in IDLE; a match while in RING/SNOOZE is ignored.
REQ-018 In RING, ring_cnt (6 bits) SHALL increment each clock; when ring_cnt==59 and no stop/snooze: RING->IDLE (auto-timeout, 60 cycles of ringing).
REQ-019 RING->IDLE when stop=1; stop has priority over snooze when both are 1 in the same cycle.
REQ-020 RING->SNOOZE when snooze=1, stop=0, snz_left>0; snz_left decrements by 1; snz_cnt (9 bits) loaded with 299.
REQ-021 snooze=1 with snz_left==0 SHALL be ignored (remain in RING, ring_cnt keeps counting).
REQ-022 In SNOOZE, snz_cnt SHALL decrement each clock; at snz_cnt==0: SNOOZE->RING, ring_cnt cleared (300 cycles in SNOOZE).
REQ-023 SNOOZE->IDLE when stop=1; snooze input ignored in SNOOZE.
REQ-024 alm_en=0 in any state SHALL force ->IDLE on the next edge, overriding all other transitions.
REQ-025 snz_left SHALL reload to 3 on every entry to IDLE.
REQ-026 buzz SHALL be 1 on the first RING cycle and toggle every clock while in RING (1,0,1,0...); 0 in IDLE and SNOOZE.
REQ-027 ringing/snoozing/buzz SHALL reflect the state registered on the same edge (no combinational path from inputs to outputs).
REQ-028 A match falling exactly at the cycle of RING->IDLE timeout SHALL NOT retrigger (cur_s is then 59/nonzero); no extra guard needed beyond REQ-016.

Reset
REQ-029 rst=0 SHALL asynchronously force state=IDLE, ring_cnt=0, snz_cnt=0, buzz=0, ringing=0, snoozing=0, snz_left=3.
REQ-030 Reset asserted mid-RING or mid-SNOOZE SHALL abort immediately; after release the block waits for the next REQ-016 match.

Configuration
REQ-031 Macro ALARM_SNOOZE_EN: defined -> SNOOZE state, snz_cnt and snooze limit per REQ-020..REQ-023.
REQ-032 Without ALARM_SNOOZE_EN: snooze input unused, SNOOZE state and snz_cnt absent, snoozing tied 0, snz_left tied 0; all other behaviour unchanged.

Verification
REQ-033 alm_en=1, alm=07:30, time steps 07:29:59->07:30:00 -> next edge ringing=1, buzz=1; buzz toggles each cycle.
REQ-034 Ringing, no input for 60 cycles -> ringing=0, buzz=0, state IDLE, snz_left=3.
REQ-035 Ringing, snooze pulse -> snoozing=1, snz_left=2; 300 cycles later ringing=1, buzz=1; four snooze requests total -> fourth ignored, snz_left stays 0.
REQ-036 Ringing, stop=1 and snooze=1 same cycle -> IDLE, snz_left=3, snoozing=0.
REQ-037 Ringing, alm_en dropped to 0 -> IDLE next edge; rst=0 mid-SNOOZE -> all outputs at reset values immediately without clock edge.
REQ-038 Build without ALARM_SNOOZE_EN, ringing, snooze=1 -> stays ringing, snoozing=0, timeout after 60 cycles.

Source files
------------

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: IDLE -> RING on an hh:mm:00 match, 60-cycle ring timeout,
// optional snooze (ALARM_SNOOZE_EN) with a 300-cycle delay and three snoozes per alarm.
module alarm_ring_ctrl (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic [5:0] cur_h,
  input  logic [5:0] cur_m,
  input  logic [5:0] cur_s,
  input  logic [5:0] alm_h,
  input  logic [5:0] alm_m,
  input  logic       alm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic       buzz,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snz_left
);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RING} state_t;
`endif

  state_t     r_state, w_nxt;
  logic [5:0] r_ring_cnt, w_ring_cnt_nxt;
  logic       r_buzz, r_ringing;
  logic       w_buzz_nxt;
  logic       w_match;

  assign w_match = (cur_h == alm_h) && (cur_m == alm_m) && (cur_s == 6'd0);

`ifdef ALARM_SNOOZE_EN
  logic [8:0] r_snz_cnt, w_snz_cnt_nxt;
  logic [1:0] r_snz_left, w_snz_left_nxt;
  logic       r_snoozing;
`else
  logic       w_unused_snooze;
  assign w_unused_snooze = snooze;
`endif

  always_comb begin
    w_nxt          = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
`ifdef ALARM_SNOOZE_EN
    w_snz_cnt_nxt  = r_snz_cnt;
    w_snz_left_nxt = r_snz_left;
`endif
    case (r_state)
      IDLE: begin
        if (alm_en && w_match) begin
          w_nxt          = RING;
          w_ring_cnt_nxt = 6'd0;
        end
      end
      RING: begin
        w_ring_cnt_nxt = r_ring_cnt + 6'd1;
        if (stop) begin
          w_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze && (r_snz_left != 2'd0)) begin
          w_nxt          = SNOOZE;
          w_snz_cnt_nxt  = 9'd299;
          w_snz_left_nxt = r_snz_left - 2'd1;
`endif
        end else if (r_ring_cnt == 6'd59) begin
          w_nxt = IDLE;
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        w_snz_cnt_nxt = r_snz_cnt - 9'd1;
        if (stop) begin
          w_nxt = IDLE;
        end else if (r_snz_cnt == 9'd0) begin
          w_nxt          = RING;
          w_ring_cnt_nxt = 6'd0;
          w_snz_cnt_nxt  = 9'd0;
        end
      end
`endif
      default: w_nxt = IDLE;
    endcase
    // Disarming wins over every other transition
    if (!alm_en) w_nxt = IDLE;
`ifdef ALARM_SNOOZE_EN
    if (w_nxt == IDLE) w_snz_left_nxt = 2'd3;
`endif
    // Fresh RING entry starts the buzzer high; staying in RING toggles it
    w_buzz_nxt = (w_nxt == RING) && !((r_state == RING) && r_buzz);
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ring_cnt <= 6'd0;
      r_buzz     <= 1'b0;
      r_ringing  <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_buzz     <= w_buzz_nxt;
      r_ringing  <= (w_nxt == RING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      r_snz_cnt  <= 9'd0;
      r_snz_left <= 2'd3;
      r_snoozing <= 1'b0;
    end else begin
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_snz_left <= w_snz_left_nxt;
      r_snoozing <= (w_nxt == SNOOZE);
    end
  end

  assign snoozing = r_snoozing;
  assign snz_left = r_snz_left;
`else
  assign snoozing = 1'b0;
  assign snz_left = 2'd0;
`endif

  assign buzz    = r_buzz;
  assign ringing = r_ringing;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl; covers both builds (ALARM_SNOOZE_EN defined or not).
module tb_alarm_ring_ctrl;
  logic       clk_1hz = 1'b0;
  logic       rst;
  logic [5:0] cur_h, cur_m, cur_s, alm_h, alm_m;
  logic       alm_en, stop, snooze;
  logic       buzz, ringing, snoozing;
  logic [1:0] snz_left;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ALARM_SNOOZE_EN
  localparam logic [1:0] FULL = 2'd3;
`else
  localparam logic [1:0] FULL = 2'd0;
`endif

  alarm_ring_ctrl dut (
    .clk_1hz(clk_1hz), .rst(rst),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .alm_h(alm_h), .alm_m(alm_m), .alm_en(alm_en),
    .stop(stop), .snooze(snooze),
    .buzz(buzz), .ringing(ringing), .snoozing(snoozing), .snz_left(snz_left)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1hz);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Step time 07:29:59 -> 07:30:00 so the following edge enters RING
  task automatic trigger();
    cur_h = 6'd7; cur_m = 6'd29; cur_s = 6'd59;
    tick(1);
    cur_m = 6'd30; cur_s = 6'd0;
    tick(1);
    cur_s = 6'd1;
  endtask

  task automatic test_reset();
    rst = 1'b0; alm_en = 1'b1; stop = 1'b0; snooze = 1'b0;
    alm_h = 6'd7; alm_m = 6'd30; cur_h = 6'd0; cur_m = 6'd0; cur_s = 6'd5;
    #3;
    chk("reset_ringing", {3'b0, ringing}, 4'd0);
    chk("reset_buzz", {3'b0, buzz}, 4'd0);
    chk("reset_snoozing", {3'b0, snoozing}, 4'd0);
    chk("reset_snz_left", {2'b0, snz_left}, {2'b0, FULL});
    tick(1);
    rst = 1'b1;
    tick(2);
    chk("post_reset_idle", {3'b0, ringing}, 4'd0);
  endtask

  task automatic test_trigger();
    cur_h = 6'd7; cur_m = 6'd29; cur_s = 6'd59;
    tick(1);
    chk("pre_match_idle", {3'b0, ringing}, 4'd0);
    cur_m = 6'd30; cur_s = 6'd0;
    tick(1);
    chk("trig_ringing", {3'b0, ringing}, 4'd1);
    chk("trig_buzz", {3'b0, buzz}, 4'd1);
    // Match still present while ringing must not restart the ring
    tick(1);
    chk("buzz_toggle0", {3'b0, buzz}, 4'd0);
    tick(1);
    chk("buzz_toggle1", {3'b0, buzz}, 4'd1);
    cur_s = 6'd3;
    tick(1);
    chk("buzz_toggle2", {3'b0, buzz}, 4'd0);
    chk("still_ringing", {3'b0, ringing}, 4'd1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_idle", {3'b0, ringing}, 4'd0);
  endtask

  task automatic test_timeout();
    trigger();
    tick(58);
    chk("to_ring_59", {3'b0, ringing}, 4'd1);
    cur_s = 6'd59;  // time at the timeout edge, so no retrigger
    tick(1);
    chk("to_ring_60", {3'b0, ringing}, 4'd1);
    chk("to_buzz_60", {3'b0, buzz}, 4'd0);
    tick(1);
    chk("to_ringing", {3'b0, ringing}, 4'd0);
    chk("to_buzz", {3'b0, buzz}, 4'd0);
    chk("to_snz_left", {2'b0, snz_left}, {2'b0, FULL});
    tick(1);
    chk("to_no_retrigger", {3'b0, ringing}, 4'd0);
  endtask

  task automatic test_stop_priority();
    trigger();
    tick(3);
    stop = 1'b1; snooze = 1'b1;
    tick(1);
    stop = 1'b0; snooze = 1'b0;
    chk("prio_ringing", {3'b0, ringing}, 4'd0);
    chk("prio_snoozing", {3'b0, snoozing}, 4'd0);
    chk("prio_snz_left", {2'b0, snz_left}, {2'b0, FULL});
  endtask

  task automatic test_alm_en_drop();
    trigger();
    tick(2);
    alm_en = 1'b0;
    tick(1);
    chk("dis_ringing", {3'b0, ringing}, 4'd0);
    chk("dis_buzz", {3'b0, buzz}, 4'd0);
    alm_en = 1'b1;
    tick(1);
    chk("dis_stays_idle", {3'b0, ringing}, 4'd0);
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze();
    trigger();
    tick(1);
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    chk("snz1_snoozing", {3'b0, snoozing}, 4'd1);
    chk("snz1_ringing", {3'b0, ringing}, 4'd0);
    chk("snz1_buzz", {3'b0, buzz}, 4'd0);
    chk("snz1_left", {2'b0, snz_left}, 4'd2);
    tick(299);
    chk("snz1_still", {3'b0, snoozing}, 4'd1);
    tick(1);
    chk("snz1_rering", {3'b0, ringing}, 4'd1);
    chk("snz1_rebuzz", {3'b0, buzz}, 4'd1);
    chk("snz1_off", {3'b0, snoozing}, 4'd0);
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    chk("snz2_left", {2'b0, snz_left}, 4'd1);
    tick(300);
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    chk("snz3_left", {2'b0, snz_left}, 4'd0);
    chk("snz3_snoozing", {3'b0, snoozing}, 4'd1);
    tick(300);
    chk("snz3_rering", {3'b0, ringing}, 4'd1);
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    chk("snz4_ignored", {3'b0, ringing}, 4'd1);
    chk("snz4_no_snooze", {3'b0, snoozing}, 4'd0);
    chk("snz4_left", {2'b0, snz_left}, 4'd0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("snz_stop_left", {2'b0, snz_left}, 4'd3);
  endtask

  task automatic test_snooze_stop_reset();
    trigger();
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    tick(5);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("sstop_snoozing", {3'b0, snoozing}, 4'd0);
    chk("sstop_ringing", {3'b0, ringing}, 4'd0);
    trigger();
    snooze = 1'b1;
    tick(1);
    snooze = 1'b0;
    tick(3);
    chk("pre_rst_snoozing", {3'b0, snoozing}, 4'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_snoozing", {3'b0, snoozing}, 4'd0);
    chk("arst_snz_left", {2'b0, snz_left}, 4'd3);
    chk("arst_ringing", {3'b0, ringing}, 4'd0);
    tick(1);
    rst = 1'b1;
    tick(2);
    chk("arst_stays_idle", {3'b0, ringing}, 4'd0);
  endtask
`else
  task automatic test_snooze_ignored();
    trigger();
    snooze = 1'b1;
    tick(1);
    chk("nosnz_ringing", {3'b0, ringing}, 4'd1);
    chk("nosnz_snoozing", {3'b0, snoozing}, 4'd0);
    chk("nosnz_left", {2'b0, snz_left}, 4'd0);
    tick(58);
    chk("nosnz_ring_60", {3'b0, ringing}, 4'd1);
    tick(1);
    snooze = 1'b0;
    chk("nosnz_timeout", {3'b0, ringing}, 4'd0);
  endtask

  task automatic test_reset_mid_ring();
    trigger();
    tick(4);
    chk("pre_rst_ringing", {3'b0, ringing}, 4'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_ringing", {3'b0, ringing}, 4'd0);
    chk("arst_buzz", {3'b0, buzz}, 4'd0);
    tick(1);
    rst = 1'b1;
    tick(2);
    chk("arst_stays_idle", {3'b0, ringing}, 4'd0);
  endtask
`endif

  initial begin
    test_reset();
    test_trigger();
    test_timeout();
    test_stop_priority();
    test_alm_en_drop();
`ifdef ALARM_SNOOZE_EN
    test_snooze();
    test_snooze_stop_reset();
`else
    test_snooze_ignored();
    test_reset_mid_ring();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
